// File: rtl/data_mem_responder.sv
// Single-outstanding CPU data memory responder with configurable wait states.
// Optional misaligned-address error reporting is enabled with `define DMEM_ALIGN_CHECK_EN.
module data_mem_responder #(
    parameter int DEPTH_LOG2  = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state_reg, state_next;
    logic [3:0]              cnt_reg, cnt_next;
    logic                    enter_resp;
    logic                    lat_write_reg;
    logic [DEPTH_LOG2-1:0]   lat_idx_reg;
    logic [31:0]             lat_wdata_reg;
    logic [3:0]              lat_be_reg;
    logic [31:0]             rdata_reg;
    logic [31:0]             mem [DEPTH];

    logic                    accept;
    logic                    acc_write;
    logic [DEPTH_LOG2-1:0]   acc_idx;
    logic [31:0]             acc_wdata;
    logic [3:0]              acc_be;
    logic                    acc_misaligned;
    logic                    mem_we;
    logic [3:0]              lane_we;

    assign accept = req_valid && (state_reg == IDLE);

    // With zero wait states the access happens on the accept edge itself,
    // so the live request fields are used instead of the latched copies.
    assign acc_write = (state_reg == IDLE) ? req_write : lat_write_reg;
    assign acc_idx   = (state_reg == IDLE) ? req_addr[DEPTH_LOG2+1:2] : lat_idx_reg;
    assign acc_wdata = (state_reg == IDLE) ? req_wdata : lat_wdata_reg;
    assign acc_be    = (state_reg == IDLE) ? req_be : lat_be_reg;

`ifdef DMEM_ALIGN_CHECK_EN
    logic [1:0] lat_lsb_reg;
    logic       err_reg;
    logic       unused_addr;

    assign acc_misaligned = ((state_reg == IDLE) ? req_addr[1:0] : lat_lsb_reg) != 2'b00;
    assign unused_addr    = ^req_addr[31:DEPTH_LOG2+2];
    assign rsp_err        = err_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lat_lsb_reg <= 2'b00;
            err_reg     <= 1'b0;
        end else begin
            if (accept) lat_lsb_reg <= req_addr[1:0];
            if (enter_resp) err_reg <= acc_misaligned;
        end
    end
`else
    logic unused_addr;

    assign acc_misaligned = 1'b0;
    assign unused_addr    = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};
    assign rsp_err        = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        enter_resp = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            lat_write_reg <= 1'b0;
            lat_idx_reg   <= '0;
            lat_wdata_reg <= 32'd0;
            lat_be_reg    <= 4'd0;
            rdata_reg     <= 32'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                lat_write_reg <= req_write;
                lat_idx_reg   <= req_addr[DEPTH_LOG2+1:2];
                lat_wdata_reg <= req_wdata;
                lat_be_reg    <= req_be;
            end
            if (enter_resp)
                rdata_reg <= (acc_write || acc_misaligned) ? 32'd0 : mem[acc_idx];
        end
    end

    // reset_n gates the write so a request seen during reset never lands in memory.
    assign mem_we = enter_resp && acc_write && !acc_misaligned && reset_n;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_we[gi] = mem_we && acc_be[gi];
        end
    endgenerate

    // Memory contents are deliberately outside the reset domain.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (lane_we[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
    end

    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == RESP);
    assign rsp_rdata = rdata_reg;

endmodule
